// File: rtl/cla32_pipe_adder.sv
// Two-stage pipelined add/subtract on 4-bit carry-lookahead groups.
// Stage 1 forms group G/P; stage 2 runs super-group lookahead and forms sum and flags.
module cla32_pipe_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = WIDTH / 4;
  localparam int NS = WIDTH / 16;

  // Four-wide lookahead: returns carries {c4, c3, c2, c1} from g/p and carry-in.
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p,
                                      input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and in_ready depends only on out_ready and state.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_bx;
  logic             s1_cin;
  logic [NG-1:0]    s1_g;
  logic [NG-1:0]    s1_p;
  logic             s2_adv;
  logic             accept;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] pb;
  logic [WIDTH-1:0] gb;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;

  assign bx = sub ? ~b : b;
  assign pb = a ^ bx;
  assign gb = a & bx;

  always_comb begin
    logic [3:0] t;
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < NG; k++) begin
      t        = cla4(gb[4*k +: 4], pb[4*k +: 4], 1'b0);
      grp_g[k] = t[3];
      grp_p[k] = &pb[4*k +: 4];
    end
  end

  // Stage 2: super-group carries ripple between 16-bit blocks, lookahead inside.
  logic [WIDTH-1:0] s2_p;
  logic [WIDTH-1:0] s2_g;
  logic [NS:0]      sc;
  logic [NS-1:0]    sg;
  logic [NS-1:0]    sp;
  logic [NG-1:0]    gc;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_c;

  assign s2_p = s1_a ^ s1_bx;
  assign s2_g = s1_a & s1_bx;

  always_comb begin
    logic [3:0] t;
    sc    = '0;
    sg    = '0;
    sp    = '0;
    gc    = '0;
    c     = '0;
    sc[0] = s1_cin;
    for (int j = 0; j < NS; j++) begin
      t         = cla4(s1_g[4*j +: 4], s1_p[4*j +: 4], 1'b0);
      sg[j]     = t[3];
      sp[j]     = &s1_p[4*j +: 4];
      sc[j+1]   = sg[j] | (sp[j] & sc[j]);
    end
    for (int j = 0; j < NS; j++) begin
      t           = cla4(s1_g[4*j +: 4], s1_p[4*j +: 4], sc[j]);
      gc[4*j]     = sc[j];
      gc[4*j + 1] = t[0];
      gc[4*j + 2] = t[1];
      gc[4*j + 3] = t[2];
    end
    for (int k = 0; k < NG; k++) begin
      t          = cla4(s2_g[4*k +: 4], s2_p[4*k +: 4], gc[k]);
      c[4*k]     = gc[k];
      c[4*k + 1] = t[0];
      c[4*k + 2] = t[1];
      c[4*k + 3] = t[2];
    end
    c[WIDTH] = sc[NS];
  end

  assign sum_c = s2_p ^ c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_bx     <= '0;
      s1_cin    <= 1'b0;
      s1_g      <= '0;
      s1_p      <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_a   <= a;
        s1_bx  <= bx;
        s1_cin <= sub;
        s1_g   <= grp_g;
        s1_p   <= grp_p;
      end
      if (s2_adv) begin
        out_valid <= 1'b1;
        sum       <= sum_c;
        cout      <= c[WIDTH];
        overflow  <= c[WIDTH-1] ^ c[WIDTH];
        zero      <= ~|sum_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla32_pipe_adder.sv
// Directed and randomized checks of cla32_pipe_adder: arithmetic, flags,
// latency, backpressure ordering and mid-flight reset.
module tb_cla32_pipe_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];

  cla32_pipe_adder #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioral reference: plain 33-bit add with two's-complement subtract.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [31:0] yx;
    logic [32:0] r;
    logic        v;
    yx = s ? ~y : y;
    r  = {1'b0, x} + {1'b0, yx} + {32'd0, s};
    v  = (x[31] == yx[31]) && (r[31] != x[31]);
    return {r[31:0], r[32], v, (r[31:0] == 32'd0)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, sum, cout, overflow, zero} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h",
               {out_valid, sum, cout, overflow, zero}, 36'd0);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                         input logic xs, input logic [31:0] es, input logic ec,
                         input logic ev, input logic ez);
    out_ready = 1'b1;
    in_valid = 1'b1; a = xa; b = xb; sub = xs;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_in_ready: got %b expected 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_latency1: out_valid got %b expected 0", name, out_valid);
    end
    tick();
    n_cmp++;
    if ({out_valid, sum, cout, overflow, zero} !== {1'b1, es, ec, ev, ez}) begin
      n_err++;
      $display("FAIL %s_result: got v=%b sum=%h c=%b ovf=%b z=%b expected v=1 sum=%h c=%b ovf=%b z=%b",
               name, out_valid, sum, cout, overflow, zero, es, ec, ev, ez);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_consume: out_valid got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd100; b = 32'd1; sub = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_op1: got %b expected 1", in_ready);
    end
    tick();
    a = 32'd200; b = 32'd2;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_op2: got %b expected 1", in_ready);
    end
    tick();
    a = 32'd300; b = 32'd3;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_ready_full: got %b expected 0", in_ready);
    end
    n_cmp++;
    if ({out_valid, sum} !== {1'b1, 32'd101}) begin
      n_err++; $display("FAIL bp_first_out: got v=%b sum=%0d expected v=1 sum=101", out_valid, sum);
    end
    tick();
    n_cmp++;
    if ({in_ready, out_valid, sum} !== {1'b0, 1'b1, 32'd101}) begin
      n_err++;
      $display("FAIL bp_hold: got rdy=%b v=%b sum=%0d expected rdy=0 v=1 sum=101",
               in_ready, out_valid, sum);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_ready_comb: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, sum} !== {1'b1, 32'd202}) begin
      n_err++; $display("FAIL bp_second_out: got v=%b sum=%0d expected v=1 sum=202", out_valid, sum);
    end
    tick();
    n_cmp++;
    if ({out_valid, sum} !== {1'b1, 32'd303}) begin
      n_err++; $display("FAIL bp_third_out: got v=%b sum=%0d expected v=1 sum=303", out_valid, sum);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drained: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd1; b = 32'd1; sub = 1'b0;
    tick();
    a = 32'd2; b = 32'd2;
    tick();
    a = 32'd3; b = 32'd3;
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, sum, cout, overflow, zero} !== 36'd0) begin
      n_err++;
      $display("FAIL midrst_outputs: got %h expected %h",
               {out_valid, sum, cout, overflow, zero}, 36'd0);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL midrst_no_output_%0d: out_valid got %b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random();
    int issued;
    int guard;
    logic [34:0] e;
    issued = 0;
    guard  = 0;
    while (issued < 10000 && guard < 60000) begin
      guard++;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = $urandom;
      b         = $urandom;
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_unexpected_output: sum=%h with empty queue", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, overflow, zero} !== e) begin
            n_err++;
            $display("FAIL rand_result: got %h expected %h", {sum, cout, overflow, zero}, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub));
        issued++;
      end
      tick();
    end
    n_cmp++;
    if (issued != 10000) begin
      n_err++; $display("FAIL rand_issue_budget: issued %0d expected 10000", issued);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_drain_unexpected: sum=%h with empty queue", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, overflow, zero} !== e) begin
            n_err++;
            $display("FAIL rand_drain_result: got %h expected %h", {sum, cout, overflow, zero}, e);
          end
        end
      end
      tick();
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rand_drain_empty: got %0d pending v=%b expected 0 pending v=0",
               exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_op("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    test_op("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    test_op("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    test_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    test_op("sub_equal",  32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    test_op("sub_zeros",  32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    test_op("add_mixed",  32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0);
    test_op("add_negneg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    test_op("add_group",  32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    test_op("add_super",  32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
